// File: rtl/dma_ctrl.sv
// DMA worker: drains the serial RX FIFO into a RAM message buffer and feeds a RAM transmit buffer to the serial transmitter.
// One RAM access burst per bus grant; the bus is released while a TX byte waits on the transmitter.
module dma_ctrl #(
  parameter logic [7:0] RX_BASE   = 8'h00,
  parameter int         MSG_LEN   = 3,
  parameter logic [7:0] FLAG_ADDR = 8'h03,
  parameter logic [7:0] FLAG_VAL  = 8'hFF,
  parameter logic [7:0] TX_BASE   = 8'h04,
  parameter int         TX_LEN    = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic       DMA_Req,
  input  logic       DMA_Ack,
  input  logic       DMA_Tx_Start,
  output logic       DMA_Ready,
  input  logic [7:0] RX_Data,
  input  logic       RX_Empty,
  output logic       RX_Pop,
  output logic [7:0] TX_Data,
  output logic       TX_Valid,
  input  logic       TX_Ready,
  output logic [7:0] RAM_Addr,
  output logic       RAM_Cs,
  output logic       RAM_Wen,
  output logic       RAM_Oen,
  output logic [7:0] RAM_Dout,
  input  logic [7:0] RAM_Din
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_REQ   = 3'd1;
  localparam logic [2:0] S_RX_WR    = 3'd2;
  localparam logic [2:0] S_RX_FLAG  = 3'd3;
  localparam logic [2:0] S_TX_REQ   = 3'd4;
  localparam logic [2:0] S_TX_RD    = 3'd5;
  localparam logic [2:0] S_TX_LATCH = 3'd6;
  localparam logic [2:0] S_TX_SEND  = 3'd7;

  localparam logic [2:0] RX_LAST = 3'(MSG_LEN - 1);
  localparam logic [2:0] TX_LAST = 3'(TX_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_pending_q, tx_pending_d;

  assign DMA_Ready = ~tx_pending_q;
  assign TX_Data   = tx_byte_q;

  always_comb begin
    state_d      = state_q;
    rx_cnt_d     = rx_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    tx_byte_d    = tx_byte_q;
    tx_pending_d = tx_pending_q | DMA_Tx_Start;
    DMA_Req      = 1'b0;
    RX_Pop       = 1'b0;
    TX_Valid     = 1'b0;
    RAM_Addr     = 8'h00;
    RAM_Cs       = 1'b0;
    RAM_Wen      = 1'b0;
    RAM_Oen      = 1'b0;
    RAM_Dout     = 8'h00;

    case (state_q)
      S_IDLE: begin
        // A start pulse arriving together with FIFO data still wins over RX.
        if (tx_pending_q || DMA_Tx_Start) state_d = S_TX_REQ;
        else if (!RX_Empty)               state_d = S_RX_REQ;
      end
      S_RX_REQ: begin
        DMA_Req = 1'b1;
        if (DMA_Ack) state_d = S_RX_WR;
      end
      S_RX_WR: begin
        DMA_Req  = 1'b1;
        RAM_Cs   = 1'b1;
        RAM_Wen  = 1'b1;
        RAM_Addr = RX_BASE + {5'b0, rx_cnt_q};
        RAM_Dout = RX_Data;
        RX_Pop   = 1'b1;
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = 3'd0;
          state_d  = S_RX_FLAG;
        end else begin
          rx_cnt_d = rx_cnt_q + 3'd1;
          state_d  = S_IDLE;
        end
      end
      S_RX_FLAG: begin
        DMA_Req  = 1'b1;
        RAM_Cs   = 1'b1;
        RAM_Wen  = 1'b1;
        RAM_Addr = FLAG_ADDR;
        RAM_Dout = FLAG_VAL;
        state_d  = S_IDLE;
      end
      S_TX_REQ: begin
        DMA_Req = 1'b1;
        if (DMA_Ack) state_d = S_TX_RD;
      end
      S_TX_RD: begin
        DMA_Req  = 1'b1;
        RAM_Cs   = 1'b1;
        RAM_Oen  = 1'b1;
        RAM_Addr = TX_BASE + {5'b0, tx_cnt_q};
        state_d  = S_TX_LATCH;
      end
      S_TX_LATCH: begin
        DMA_Req   = 1'b1;
        tx_byte_d = RAM_Din;
        state_d   = S_TX_SEND;
      end
      S_TX_SEND: begin
        TX_Valid = 1'b1;
        if (TX_Ready) begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d     = 3'd0;
            tx_pending_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 3'd1;
            state_d  = S_TX_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      rx_cnt_q     <= 3'd0;
      tx_cnt_q     <= 3'd0;
      tx_byte_q    <= 8'h00;
      tx_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_byte_q    <= tx_byte_d;
      tx_pending_q <= tx_pending_d;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: RAM/FIFO/transmitter models plus a transaction-level reference of expected RAM writes and TX bytes.
module tb_dma_ctrl;

  localparam logic [7:0] RX_BASE   = 8'h00;
  localparam int         MSG_LEN   = 3;
  localparam logic [7:0] FLAG_ADDR = 8'h03;
  localparam logic [7:0] FLAG_VAL  = 8'hFF;
  localparam logic [7:0] TX_BASE   = 8'h04;
  localparam int         TX_LEN    = 2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       DMA_Req, DMA_Ack, DMA_Tx_Start, DMA_Ready;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       RX_Pop;
  logic [7:0] TX_Data;
  logic       TX_Valid, TX_Ready;
  logic [7:0] RAM_Addr, RAM_Dout, ram_din;
  logic       RAM_Cs, RAM_Wen, RAM_Oen;

  always #5 Clk = ~Clk;

  dma_ctrl #(
    .RX_BASE(RX_BASE), .MSG_LEN(MSG_LEN), .FLAG_ADDR(FLAG_ADDR),
    .FLAG_VAL(FLAG_VAL), .TX_BASE(TX_BASE), .TX_LEN(TX_LEN)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack), .DMA_Tx_Start(DMA_Tx_Start), .DMA_Ready(DMA_Ready),
    .RX_Data(rx_data), .RX_Empty(rx_empty), .RX_Pop(RX_Pop),
    .TX_Data(TX_Data), .TX_Valid(TX_Valid), .TX_Ready(TX_Ready),
    .RAM_Addr(RAM_Addr), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
    .RAM_Dout(RAM_Dout), .RAM_Din(ram_din)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment models
  logic [7:0] mem [0:255];
  logic [7:0] fifo_q [$];
  logic [1:0] ack_mode;   // 0: tied to request, 1: random delayed grant, 2: withheld
  logic       ack_r;
  logic [1:0] tx_mode;    // 0: always ready, 1: random, 2: ready 5 cycles after valid
  int         v_age;
  int         pops, pushes;

  assign DMA_Ack = DMA_Req & ((ack_mode == 2'd0) | ((ack_mode == 2'd1) & ack_r));

  always @(posedge Clk) begin
    if (RAM_Cs && RAM_Wen) mem[RAM_Addr] = RAM_Dout;
    if (RAM_Cs && RAM_Oen) ram_din <= mem[RAM_Addr];
    if (RX_Pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
      rx_empty = (fifo_q.size() == 0);
      rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  always @(posedge Clk) begin
    #1;
    if (!DMA_Req) ack_r = 1'b0;
    else if (!ack_r && $urandom_range(0, 2) == 0) ack_r = 1'b1;
    if (TX_Valid) v_age++;
    else v_age = 0;
    case (tx_mode)
      2'd0:    TX_Ready = 1'b1;
      2'd1:    TX_Ready = 1'($urandom_range(0, 1));
      default: TX_Ready = (v_age > 5);
    endcase
  end

  // Reference model: expected write stream and expected TX byte stream
  logic [7:0] exp_wa [$];
  logic [7:0] exp_wd [$];
  logic [7:0] exp_tx [$];
  int         rx_k;
  bit         tx_pend;
  int         tx_left;
  int         hs_cnt, req_rises;
  bit         mon_en, prev_wait, prev_req, fin;
  logic [7:0] prev_data;

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    rx_empty = 1'b0;
    rx_data  = fifo_q[0];
    pushes++;
    exp_wa.push_back(RX_BASE + 8'(rx_k % MSG_LEN));
    exp_wd.push_back(b);
    if (rx_k % MSG_LEN == MSG_LEN - 1) begin
      exp_wa.push_back(FLAG_ADDR);
      exp_wd.push_back(FLAG_VAL);
    end
    rx_k++;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      fin = 1'b0;
      chk("ready_vs_pending", DMA_Ready, !tx_pend);
      if (RAM_Cs && RAM_Wen) begin
        chk("wr_granted", DMA_Ack, 1);
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", RAM_Addr, exp_wa.pop_front());
          chk("wr_data", RAM_Dout, exp_wd.pop_front());
        end
      end
      if (RAM_Cs && RAM_Oen) chk("rd_granted", DMA_Ack, 1);
      if (!RAM_Cs) chk("ram_quiet", {RAM_Wen, RAM_Oen, RAM_Addr, RAM_Dout}, 0);
      if (TX_Valid) chk("bus_released", DMA_Req, 0);
      if (prev_wait) chk("tx_hold", TX_Data, prev_data);
      prev_wait = TX_Valid && !TX_Ready;
      prev_data = TX_Data;
      if (DMA_Req && !prev_req) req_rises++;
      prev_req = DMA_Req;
      if (TX_Valid && TX_Ready) begin
        hs_cnt++;
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          chk("tx_data", TX_Data, exp_tx.pop_front());
          tx_left--;
          fin = (tx_left == 0);
        end
      end
      if (DMA_Tx_Start && !tx_pend) begin
        tx_pend = 1'b1;
        tx_left = TX_LEN;
        for (int i = 0; i < TX_LEN; i++) exp_tx.push_back(mem[8'(TX_BASE + 8'(i))]);
      end else if (fin) begin
        tx_pend = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge Clk);
      done = (exp_wa.size() == 0) && (exp_tx.size() == 0) && (fifo_q.size() == 0) &&
             !DMA_Req && !TX_Valid && DMA_Ready;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_write(input string tag, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge Clk);
      seen = RAM_Cs && RAM_Wen;
    end
    chk(tag, seen, 1);
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  int hs0, pops0, rises0;

  initial begin
    Rst = 1'b1; DMA_Tx_Start = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
    ack_mode = 2'd0; ack_r = 1'b0; tx_mode = 2'd0; TX_Ready = 1'b0; v_age = 0;
    pops = 0; pushes = 0; rx_k = 0; tx_pend = 1'b0; tx_left = 0; hs_cnt = 0; req_rises = 0;
    mon_en = 1'b0; prev_wait = 1'b0; prev_req = 1'b0; prev_data = 8'h00; fin = 1'b0; ram_din = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) step();
    Rst = 1'b0;

    // Asynchronous reset in the middle of an RX write
    step();
    fifo_q.push_back(8'h5A); rx_empty = 1'b0; rx_data = 8'h5A;
    wait_write("rst_reach_wr", 10);
    #1 Rst = 1'b1;
    #1;
    chk("rst_req", DMA_Req, 0);
    chk("rst_ready", DMA_Ready, 1);
    chk("rst_pop", RX_Pop, 0);
    chk("rst_valid", TX_Valid, 0);
    chk("rst_txdata", TX_Data, 0);
    chk("rst_ram", {RAM_Cs, RAM_Wen, RAM_Oen, RAM_Addr, RAM_Dout}, 0);
    step();
    chk("rst_no_write", mem[RX_BASE], 0);
    chk("rst_no_pop", fifo_q.size(), 1);
    fifo_q.delete(); rx_empty = 1'b1; rx_data = 8'h00; pops = 0;
    step();
    Rst = 1'b0;
    mon_en = 1'b1;

    // RX message with grant tied to request
    step();
    pops0 = pops; rises0 = req_rises;
    push(8'h41);
    @(negedge Clk); chk("rx_lat_c0_req", DMA_Req, 0);
    @(negedge Clk); chk("rx_lat_c1_req", DMA_Req, 1); chk("rx_lat_c1_cs", RAM_Cs, 0);
    @(negedge Clk); chk("rx_lat_c2_wr", {RAM_Cs, RAM_Wen, RX_Pop}, 3'b111);
    @(negedge Clk); chk("rx_lat_c3_req", DMA_Req, 0);
    step();
    push(8'h42); push(8'h43);
    wait_idle("rx_msg_done", 60);
    chk("rx_mem0", mem[0], 8'h41);
    chk("rx_mem1", mem[1], 8'h42);
    chk("rx_mem2", mem[2], 8'h43);
    chk("rx_flag", mem[3], 8'hFF);
    chk("rx_pops", pops - pops0, 3);
    chk("rx_req_rises", req_rises - rises0, 3);

    // TX of two bytes with a slow transmitter
    mem[4] = 8'h55; mem[5] = 8'hAA;
    tx_mode = 2'd2;
    hs0 = hs_cnt;
    step(); DMA_Tx_Start = 1'b1;
    step(); DMA_Tx_Start = 1'b0;
    begin
      bit got_req = 1'b0;
      for (int c = 0; c < 10 && !got_req; c++) begin
        @(negedge Clk);
        got_req = DMA_Req;
      end
      chk("tx_req_seen", got_req, 1);
    end
    @(negedge Clk); chk("tx_lat_c1", TX_Valid, 0);
    @(negedge Clk); chk("tx_lat_c2", TX_Valid, 0);
    @(negedge Clk); chk("tx_lat_c3", TX_Valid, 1);
    wait_idle("tx_done", 80);
    chk("tx_handshakes", hs_cnt - hs0, TX_LEN);
    chk("tx_ready_after", DMA_Ready, 1);

    // Start and a new RX byte in the same cycle: TX must finish first
    tx_mode = 2'd0;
    hs0 = hs_cnt;
    step(); push(8'h99); DMA_Tx_Start = 1'b1;
    step(); DMA_Tx_Start = 1'b0;
    wait_write("prio_write_seen", 40);
    chk("prio_tx_first", hs_cnt - hs0, TX_LEN);
    chk("prio_addr", RAM_Addr, RX_BASE);
    chk("prio_data", RAM_Dout, 8'h99);
    wait_idle("prio_done", 40);

    // Grant withheld for 10 cycles
    ack_mode = 2'd2;
    step(); push(8'h77);
    @(negedge Clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      chk("hold_req", {DMA_Req, RAM_Cs}, 2'b10);
    end
    ack_mode = 2'd0;
    @(negedge Clk);
    chk("hold_write_next", {RAM_Cs, RAM_Wen}, 2'b11);
    chk("hold_addr", RAM_Addr, RX_BASE + 8'd1);
    wait_idle("hold_done", 40);

    // Second start pulse while a transmission is in progress
    mem[4] = 8'($urandom); mem[5] = 8'($urandom);
    tx_mode = 2'd2;
    hs0 = hs_cnt;
    step(); DMA_Tx_Start = 1'b1;
    step(); DMA_Tx_Start = 1'b0;
    begin
      bit vseen = 1'b0;
      for (int c = 0; c < 20 && !vseen; c++) begin
        @(negedge Clk);
        vseen = TX_Valid;
      end
      chk("extra_valid_seen", vseen, 1);
    end
    step(); DMA_Tx_Start = 1'b1;
    step(); DMA_Tx_Start = 1'b0;
    wait_idle("extra_done", 80);
    chk("extra_ignored", hs_cnt - hs0, TX_LEN);

    // Randomized traffic against the reference model
    ack_mode = 2'd1;
    tx_mode  = 2'd1;
    mem[4] = 8'($urandom); mem[5] = 8'($urandom);
    for (int c = 0; c < 2500; c++) begin
      step();
      DMA_Tx_Start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0 && fifo_q.size() < 8) push(8'($urandom));
    end
    step(); DMA_Tx_Start = 1'b0;
    wait_idle("rand_drain", 600);
    chk("rand_pops", pops, pushes);
    chk("rand_writes_left", exp_wa.size(), 0);
    chk("rand_tx_left", exp_tx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

DMA controller at the peripheral end of the CPU's DMA handshake: bus requester toward `DMA_Req`/`DMA_Ack`, and the worker behind `DMA_Tx_Start`/`DMA_Ready`. It moves bytes between the serial receive FIFO, the shared RAM and the serial transmitter. Received bytes are written into a RAM message buffer, with a flag written on message completion. On CPU command, a RAM transmit buffer is read and fed to the transmitter. The top level muxes the RAM port to this block while `DMA_Ack`=1.

## Interface
- `RX_BASE`, 8'h00, RAM address of received-message byte 0
- `MSG_LEN`, 3, bytes per received message (1..8)
- `FLAG_ADDR`, 8'h03, RAM address written on message completion
- `FLAG_VAL`, 8'hFF, value written to `FLAG_ADDR`
- `TX_BASE`, 8'h04, RAM address of transmit byte 0
- `TX_LEN`, 2, bytes per transmission (1..8)

- `Clk`  in  1  clock, rising edge
- `Rst`  in  1  reset, asynchronous, active-high
- `DMA_Req`  out  1  bus request to CPU
- `DMA_Ack`  in  1  bus grant from CPU
- `DMA_Tx_Start`  in  1  one-cycle transmit command from CPU
- `DMA_Ready`  out  1  1 = no transmission pending or active
- `RX_Data`  in  8  FIFO head byte (first-word-fall-through)
- `RX_Empty`  in  1  FIFO empty
- `RX_Pop`  out  1  one-cycle FIFO pop
- `TX_Data`  out  8  byte to transmitter
- `TX_Valid`  out  1  `TX_Data` valid
- `TX_Ready`  in  1  transmitter accepts when `TX_Valid`&`TX_Ready`
- `RAM_Addr`  out  8  RAM address
- `RAM_Cs`  out  1  chip select, active-high
- `RAM_Wen`  out  1  write enable, active-high
- `RAM_Oen`  out  1  output enable (read), active-high
- `RAM_Dout`  out  8  write data
- `RAM_Din`  in  8  read data, valid the cycle after `RAM_Cs`&`RAM_Oen`

## Operation
- FSM states: IDLE, RX_REQ, RX_WR, RX_FLAG, TX_REQ, TX_RD, TX_LATCH, TX_SEND.
- `DMA_Req`=1 exactly in RX_REQ, RX_WR, RX_FLAG, TX_REQ, TX_RD, TX_LATCH. It is a Moore output.
- Counters `rx_cnt` and `tx_cnt` are 3 bits. Address = base + cnt, computed modulo 256.
- `tx_pending` register:
  - Set by `DMA_Tx_Start` in any state when clear; the pulse is ignored when already set.
  - `DMA_Ready` = !`tx_pending`.
- IDLE: if `tx_pending`, go to TX_REQ. Else if !`RX_Empty`, go to RX_REQ. TX has priority.
- RX_REQ: wait for `DMA_Ack`=1, then go to RX_WR.
- RX_WR (one cycle):
  - Outputs: `RAM_Cs`=`RAM_Wen`=1, `RAM_Addr`=RX_BASE+rx_cnt, `RAM_Dout`=`RX_Data`, `RX_Pop`=1.
  - If rx_cnt==MSG_LEN-1: rx_cnt←0, go to RX_FLAG. Else rx_cnt++, go to IDLE.
- RX_FLAG (one cycle): write FLAG_VAL to FLAG_ADDR, then go to IDLE.
- One RX byte per bus grant, so the CPU runs between bytes.
- TX_REQ: wait for `DMA_Ack`=1, then go to TX_RD.
- TX_RD: `RAM_Cs`=`RAM_Oen`=1, `RAM_Addr`=TX_BASE+tx_cnt, then go to TX_LATCH.
- TX_LATCH: tx_byte←`RAM_Din`, then go to TX_SEND.
- TX_SEND:
  - Bus released; `TX_Valid`=1, `TX_Data`=tx_byte, held stable until `TX_Ready`.
  - On handshake: if tx_cnt==TX_LEN-1, tx_cnt←0, `tx_pending`←0, go to IDLE. Else tx_cnt++, go to TX_REQ.
- RAM outputs are all 0 in every state not listed above.
- A partially received message persists across transmissions; rx_cnt is not cleared by TX.

## Timing
- Reset values: `DMA_Req`=0, `DMA_Ready`=1, `RX_Pop`=0, `TX_Valid`=0, `TX_Data`=0, all RAM outputs 0.
- Reset clears the FSM (to IDLE), counters, tx_byte and `tx_pending`. Reset mid-transfer abandons it with no further RAM or FIFO access.
- RX latency, byte available with bus idle:
  - IDLE→RX_REQ: 1 cycle.
  - `DMA_Req` high from cycle 1.
  - The write occurs in the cycle after `DMA_Ack` is first seen high.
  - `DMA_Req` falls 1 cycle after the last write.
- TX:
  - `DMA_Ready` falls the cycle after `DMA_Tx_Start`.
  - `TX_Valid` rises 3 cycles after the grant is seen.
  - `DMA_Ready` rises the cycle after the final handshake.
- Simultaneous `DMA_Tx_Start` and non-empty FIFO in IDLE: TX is served first. RX waits, and bytes stay in the FIFO.
- `DMA_Tx_Start` during RX: latched; TX starts from the next IDLE.
- `DMA_Ack` low in RX_WR/TX_RD/TX_LATCH is a protocol violation. No recovery is required.

## Test plan
- Reset: assert `Rst` asynchronously mid-RX_WR → all outputs take reset values immediately, and `DMA_Ready`=1.
- RX message: push 8'h41, 8'h42, 8'h43 with `DMA_Ack` tied to `DMA_Req` → RAM[0..2]=41,42,43; RAM[3]=FF; three `RX_Pop` pulses; `DMA_Req` drops between bytes.
- TX: RAM[4]=8'h55, RAM[5]=8'hAA; pulse `DMA_Tx_Start`; `TX_Ready` high 5 cycles after each `TX_Valid` → bytes 55 then AA delivered, `TX_Data` held stable while waiting, `DMA_Ready` 0→1 after the second handshake.
- Priority: `DMA_Tx_Start` in the same cycle a byte arrives → both TX bytes read from RAM before any RX write; the RX byte then lands at RAM[0].
- Delayed grant: hold `DMA_Ack`=0 for 10 cycles → FSM stays in RX_REQ with no RAM strobe; write occurs the cycle after `DMA_Ack` rises.
- Extra `DMA_Tx_Start` pulse mid-transmission → ignored; exactly TX_LEN bytes sent.
